// File: rtl/ipm_red_decode_if.sv
`default_nettype none
// ============================================================================
//  Module   : ipm_red_decode_if
//  Purpose  : Request/result bundle for the IPM-RED unmasking block.
//             The master drives the request (start, Z, L1, L2) and the slave
//             returns status and result (busy, done, x, fault).
//  Ports    : start      - request pulse
//             Z, L1, L2  - V bytes each, byte i at [8i+7:8i]
//             busy, done - decode status
//             x, fault   - decoded byte and redundancy-check flag
//  Revision : 1.0 - initial release
// ============================================================================
interface ipm_red_decode_if #(
  parameter int V = 8
);
  logic           start;
  logic [V*8-1:0] Z;
  logic [V*8-1:0] L1;
  logic [V*8-1:0] L2;
  logic           busy;
  logic           done;
  logic [7:0]     x;
  logic           fault;

  modport master (output start, Z, L1, L2, input busy, done, x, fault);
  modport slave  (input start, Z, L1, L2, output busy, done, x, fault);
endinterface
`default_nettype wire

// File: rtl/ipm_red_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ipm_red_decode
//  Purpose  : Sequential IPM-RED unmasking over GF(2^8) (poly 0x11B).
//             Computes x = <L1,Z> and y = <L2,Z> one share per cycle, then
//             checks y == x^3. On mismatch x is forced to 0 and fault is set.
//             This is the only point where a clear byte leaves the masked
//             domain, so latched share material is wiped after every decode.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - ipm_red_decode_if.slave (start/Z/L1/L2 in,
//                    busy/done/x/fault out)
//  Revision : 1.0 - initial release
// ============================================================================
module ipm_red_decode #(
  parameter int V = 8
) (
  input  logic               clk,
  input  logic               rst,
  ipm_red_decode_if.slave    bus
);

  localparam int IW = $clog2(V);

  localparam logic [1:0]    c_idle = 2'd0;
  localparam logic [1:0]    c_acc  = 2'd1;
  localparam logic [1:0]    c_sq   = 2'd2;
  localparam logic [1:0]    c_cube = 2'd3;
  localparam logic [IW-1:0] c_last = IW'(V - 1);

  // GF(2^8) multiply, shift-and-add with reduction by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  logic [1:0]     r_state;
  logic [IW-1:0]  r_idx;
  logic [V*8-1:0] r_z;
  logic [V*8-1:0] r_l1;
  logic [V*8-1:0] r_l2;
  logic [7:0]     r_acc1;
  logic [7:0]     r_acc2;
  logic [7:0]     r_sq;
  logic           r_busy;
  logic           r_done;
  logic [7:0]     r_x;
  logic           r_fault;

  logic [7:0] w_z_i;
  logic [7:0] w_l1_i;
  logic [7:0] w_l2_i;
  logic [7:0] w_m0_a;
  logic [7:0] w_m0_b;
  logic [7:0] w_m1_a;
  logic [7:0] w_m1_b;
  logic [7:0] w_mul0;
  logic [7:0] w_mul1;
  logic       w_fault;

  assign w_z_i  = r_z [int'(r_idx)*8 +: 8];
  assign w_l1_i = r_l1[int'(r_idx)*8 +: 8];
  assign w_l2_i = r_l2[int'(r_idx)*8 +: 8];

  // Operand steering for the two shared multipliers.
  // ACC : m0 = L1[i]*Z[i], m1 = L2[i]*Z[i]
  // SQ  : m0 = acc1*acc1
  // CUBE: m1 = sq*acc1
  always_comb begin
    w_m0_a = 8'h00;
    w_m0_b = 8'h00;
    w_m1_a = 8'h00;
    w_m1_b = 8'h00;
    case (r_state)
      c_acc: begin
        w_m0_a = w_l1_i;
        w_m0_b = w_z_i;
        w_m1_a = w_l2_i;
        w_m1_b = w_z_i;
      end
      c_sq: begin
        w_m0_a = r_acc1;
        w_m0_b = r_acc1;
      end
      c_cube: begin
        w_m1_a = r_sq;
        w_m1_b = r_acc1;
      end
      default: ;
    endcase
  end

  assign w_mul0  = gf_mul(w_m0_a, w_m0_b);
  assign w_mul1  = gf_mul(w_m1_a, w_m1_b);
  assign w_fault = (w_mul1 != r_acc2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
      r_idx   <= '0;
      r_z     <= '0;
      r_l1    <= '0;
      r_l2    <= '0;
      r_acc1  <= 8'h00;
      r_acc2  <= 8'h00;
      r_sq    <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_x     <= 8'h00;
      r_fault <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (bus.start) begin
            r_z     <= bus.Z;
            r_l1    <= bus.L1;
            r_l2    <= bus.L2;
            r_acc1  <= 8'h00;
            r_acc2  <= 8'h00;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= c_acc;
          end
        end
        c_acc: begin
          r_acc1 <= r_acc1 ^ w_mul0;
          r_acc2 <= r_acc2 ^ w_mul1;
          if (r_idx == c_last) begin
            r_idx   <= '0;
            r_state <= c_sq;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        c_sq: begin
          r_sq    <= w_mul0;
          r_state <= c_cube;
        end
        c_cube: begin
          r_fault <= w_fault;
          r_x     <= w_fault ? 8'h00 : r_acc1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          // Wipe every trace of the shares before going idle.
          r_z     <= '0;
          r_l1    <= '0;
          r_l2    <= '0;
          r_acc1  <= 8'h00;
          r_acc2  <= 8'h00;
          r_sq    <= 8'h00;
          r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.x     = r_x;
  assign bus.fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_ipm_red_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ipm_red_decode
//  Purpose  : Directed self-checking bench for ipm_red_decode (V = 8) with
//             hand-computed expected results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ipm_red_decode;

  localparam int V = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ipm_red_decode_if #(.V(V)) intf ();

  ipm_red_decode #(.V(V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start high across one rising edge (the accept edge).
  task automatic launch(input logic [63:0] z, input logic [63:0] l1, input logic [63:0] l2);
    intf.Z     = z;
    intf.L1    = l1;
    intf.L2    = l2;
    intf.start = 1'b1;
    step();
    intf.start = 1'b0;
    // Scramble the inputs: only latched copies may be used.
    intf.Z     = ~z;
    intf.L1    = ~l1;
    intf.L2    = ~l2;
  endtask

  // Count edges from the accept edge until done; expect exactly 10.
  task automatic wait_done(input int already, input string tag,
                           input logic [7:0] exp_x, input logic exp_fault);
    int cnt;
    bit seen;
    bit busy_ok;
    cnt     = already;
    seen    = 1'b0;
    busy_ok = 1'b1;
    if (already == 0 && intf.busy !== 1'b1) busy_ok = 1'b0;
    while (!seen && cnt < 40) begin
      step();
      cnt++;
      if (intf.done === 1'b1) seen = 1'b1;
      else if (intf.busy !== 1'b1) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, cnt, 10);
    check({tag, "_busy_during"}, {31'd0, busy_ok}, 1);
    check({tag, "_busy_at_done"}, {31'd0, intf.busy}, 0);
    check({tag, "_x"}, {24'd0, intf.x}, {24'd0, exp_x});
    check({tag, "_fault"}, {31'd0, intf.fault}, {31'd0, exp_fault});
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    intf.start = 1'b0;
    intf.Z     = '0;
    intf.L1    = '0;
    intf.L2    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, intf.busy},  0);
    check("rst_done",  {31'd0, intf.done},  0);
    check("rst_x",     {24'd0, intf.x},     0);
    check("rst_fault", {31'd0, intf.fault}, 0);
    rst = 1'b0;
    step();

    // 2^3 = 8 -> consistent
    launch(64'h0802, 64'h01, 64'h0100);
    wait_done(0, "t1", 8'h02, 1'b0);
    step();
    check("t1_done_one_cycle", {31'd0, intf.done}, 0);
    repeat (3) step();
    check("t1_x_hold", {24'd0, intf.x}, 32'h02);

    // 3^3 = 0x0F -> consistent
    launch(64'h0F03, 64'h01, 64'h0100);
    wait_done(0, "t2a", 8'h03, 1'b0);
    step();

    // corrupted redundancy
    launch(64'h0E03, 64'h01, 64'h0100);
    wait_done(0, "t2b", 8'h00, 1'b1);
    step();

    // acc1 = 1^2^..^8 = 8, 8^3 = 0x36 != 0
    launch(64'h0807060504030201, 64'h0101010101010101, 64'h0);
    wait_done(0, "t3", 8'h00, 1'b1);
    repeat (2) step();
    check("t3_fault_hold", {31'd0, intf.fault}, 1);

    // all zero: 0^3 = 0 -> consistent, fault cleared
    launch(64'h0, 64'h0, 64'h0);
    wait_done(0, "t4", 8'h00, 1'b0);
    step();

    // start re-pulsed during a decode is ignored
    launch(64'h0802, 64'h01, 64'h0100);
    step();
    step();
    intf.Z     = 64'h0E03;
    intf.L1    = 64'h01;
    intf.L2    = 64'h0100;
    intf.start = 1'b1;
    step();
    intf.start = 1'b0;
    wait_done(3, "t5a", 8'h02, 1'b0);
    // start in the done cycle is accepted
    launch(64'h0F03, 64'h01, 64'h0100);
    wait_done(0, "t5b", 8'h03, 1'b0);
    step();

    // reset mid-decode aborts with no done
    launch(64'h0F03, 64'h01, 64'h0100);
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("t6_busy",  {31'd0, intf.busy},  0);
    check("t6_done",  {31'd0, intf.done},  0);
    check("t6_x",     {24'd0, intf.x},     0);
    check("t6_fault", {31'd0, intf.fault}, 0);
    step();
    rst = 1'b0;
    begin
      bit any_done;
      any_done = 1'b0;
      for (int k = 0; k < 12; k++) begin
        step();
        if (intf.done === 1'b1) any_done = 1'b1;
      end
      check("t6_no_done", {31'd0, any_done}, 0);
    end
    launch(64'h0802, 64'h01, 64'h0100);
    wait_done(0, "t6_after", 8'h02, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
